// File: rtl/avmm_multi_interval_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer.
// The master drives the select, strobes, address and write data.
// The slave returns registered read data.
interface avmm_multi_interval_timer_if #(
   parameter int ADDR_W = 5
);
   logic              chipselect;
   logic              write_n;
   logic              read_n;
   logic [ADDR_W-1:0] address;
   logic [31:0]       writedata;
   logic [31:0]       readdata;

   modport master (
      output chipselect, write_n, read_n, address, writedata,
      input  readdata
   );

   modport slave (
      input  chipselect, write_n, read_n, address, writedata,
      output readdata
   );
endinterface

// File: rtl/avmm_multi_interval_timer.sv
// NUM_CH independent CNT_W-bit interval timers behind one 32-bit Avalon-MM slave.
// Address layout is {channel, reg[2:0]}. Each channel has these registers:
//   0 STATUS   : [0]=TO, [1]=RUN. Any write clears TO.
//   1 CONTROL  : [0]=ITO and [1]=CONT are stored; [2]=START and [3]=STOP are strobes.
//   2 PERIOD   : a write also stops the channel and reloads the counter.
//   3 SNAP     : a write captures the counter; a read returns the capture.
//   4 PRESCALE : present only when TIMER_PRESCALER_EN is defined.
//   5 IRQVEC   : read-only copy of irq_vec.
// Optional feature macro: TIMER_PRESCALER_EN adds a 16-bit prescaler per channel.
module avmm_multi_interval_timer #(
   parameter int          NUM_CH       = 4,
   parameter int          CNT_W        = 32,
   parameter logic [31:0] RESET_PERIOD = 32'h22E97
) (
   input  logic                       clk,
   input  logic                       reset_n,
   avmm_multi_interval_timer_if.slave bus,
   output logic [NUM_CH-1:0]          irq_vec,
   output logic                       irq
);

   localparam int               ADDR_W  = $clog2(NUM_CH) + 3;
   localparam logic [CNT_W-1:0] RST_CNT = RESET_PERIOD[CNT_W-1:0];

   localparam logic [2:0] REG_STATUS   = 3'd0;
   localparam logic [2:0] REG_CONTROL  = 3'd1;
   localparam logic [2:0] REG_PERIOD   = 3'd2;
   localparam logic [2:0] REG_SNAP     = 3'd3;
   localparam logic [2:0] REG_PRESCALE = 3'd4;
   localparam logic [2:0] REG_IRQVEC   = 3'd5;

   logic [3:0]               ch_sel;
   logic [2:0]               reg_sel;
   logic                     wr_en;
   logic [NUM_CH-1:0][31:0]  ch_rd;
   logic [31:0]              rd_next;
   logic [31:0]              rd_data_p1;
   logic                     unused_bits;

   // Single-channel builds have no channel field in the address.
   generate
      if (ADDR_W > 3) begin : g_chsel
         assign ch_sel = 4'(bus.address[ADDR_W-1:3]);
      end else begin : g_chsel_one
         assign ch_sel = 4'd0;
      end
   endgenerate

   assign reg_sel     = bus.address[2:0];
   assign wr_en       = bus.chipselect & ~bus.write_n;
   assign unused_bits = ^{bus.read_n, bus.writedata};

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         logic [CNT_W-1:0] cnt;
         logic [CNT_W-1:0] period;
         logic [CNT_W-1:0] snap;
         logic             run;
         logic             to;
         logic             ito;
         logic             cont;
         logic             zero_q;
         logic             reload_pend;
         logic             wr_ch;
         logic             cnt_zero;
         logic             evt;
         logic             tick;
         logic [31:0]      rd_val;

         assign wr_ch    = wr_en && (ch_sel == 4'(i));
         assign cnt_zero = (cnt == '0);
         // Timeout is the edge into zero.
         // A counter parked at zero therefore raises TO only once.
         assign evt      = cnt_zero && !zero_q;

`ifdef TIMER_PRESCALER_EN
         logic [15:0] prescale;
         logic [15:0] pcnt;

         assign tick = (pcnt == 16'd0);

         // Prescale divider.
         // Restarts from PRESCALE on START and on a PERIOD write, so the first
         // period after a (re)start is always full length.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               prescale <= 16'd0;
               pcnt     <= 16'd0;
            end else begin
               if (wr_ch && (reg_sel == REG_PRESCALE))
                  prescale <= bus.writedata[15:0];
               if (wr_ch && ((reg_sel == REG_PERIOD) ||
                             ((reg_sel == REG_CONTROL) && bus.writedata[2])))
                  pcnt <= prescale;
               else if (run)
                  pcnt <= tick ? prescale : pcnt - 16'd1;
            end
         end
`else
         assign tick = 1'b1;
`endif

         // Channel counter, run/timeout state and register writes.
         // Writes come last so they override the counting logic.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt         <= RST_CNT;
               period      <= RST_CNT;
               snap        <= '0;
               run         <= 1'b0;
               to          <= 1'b0;
               ito         <= 1'b0;
               cont        <= 1'b0;
               zero_q      <= 1'b0;
               reload_pend <= 1'b0;
            end else begin
               zero_q      <= cnt_zero;
               reload_pend <= 1'b0;
               if (reload_pend) begin
                  cnt <= period;
               end else if (run && tick) begin
                  if (cnt_zero) begin
                     if (cont) cnt <= period;
                     else      run <= 1'b0;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               if (evt) to <= 1'b1;
               if (wr_ch) begin
                  case (reg_sel)
                     REG_STATUS: to <= 1'b0;
                     REG_CONTROL: begin
                        ito  <= bus.writedata[0];
                        cont <= bus.writedata[1];
                        if (bus.writedata[2])      run <= 1'b1;
                        else if (bus.writedata[3]) run <= 1'b0;
                     end
                     REG_PERIOD: begin
                        period      <= bus.writedata[CNT_W-1:0];
                        run         <= 1'b0;
                        reload_pend <= 1'b1;
                     end
                     REG_SNAP: snap <= cnt;
                     default: ;
                  endcase
               end
            end
         end

         // Read value of the addressed register in this channel.
         always_comb begin
            rd_val = '0;
            case (reg_sel)
               REG_STATUS:  rd_val[1:0]       = {run, to};
               REG_CONTROL: rd_val[1:0]       = {cont, ito};
               REG_PERIOD:  rd_val[CNT_W-1:0] = period;
               REG_SNAP:    rd_val[CNT_W-1:0] = snap;
`ifdef TIMER_PRESCALER_EN
               REG_PRESCALE: rd_val[15:0]     = prescale;
`endif
               REG_IRQVEC:  rd_val[NUM_CH-1:0] = irq_vec;
               default: ;
            endcase
         end

         assign ch_rd[i]   = rd_val;
         assign irq_vec[i] = to & ito;
      end
   endgenerate

   assign irq = |irq_vec;

   // Channel read mux.
   // Channel numbers beyond NUM_CH match nothing and read as zero.
   always_comb begin
      rd_next = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_sel == 4'(i)) rd_next = ch_rd[i];
      end
   end

   // Read data is registered every cycle.
   // It is valid one clock after the address is presented.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_data_p1 <= '0;
      else          rd_data_p1 <= rd_next;
   end

   assign bus.readdata = rd_data_p1;

endmodule

// File: tb/tb_avmm_multi_interval_timer.sv
// Bench for avmm_multi_interval_timer.
// Table-driven register vectors are followed by sequences for timing corner cases.
// Read expectations pass through a scoreboard queue.
module tb_avmm_multi_interval_timer;
   localparam int NUM_CH = 4;
   localparam int ADDR_W = 5;

`ifdef TIMER_PRESCALER_EN
   localparam logic [31:0] EXP_PS = 32'h0000_2345;
`else
   localparam logic [31:0] EXP_PS = 32'h0;
`endif

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [NUM_CH-1:0] irq_vec;
   logic              irq;

   int cyc       = 0;
   int n_checks  = 0;
   int n_errors  = 0;
   int last_edge = 0;
   int last_rise = -1;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      bit          wr;
      logic [4:0]  addr;
      logic [31:0] data;
      string       name;
   } vec_t;
   vec_t vecs[$];

   avmm_multi_interval_timer_if #(.ADDR_W(ADDR_W)) bus ();

   avmm_multi_interval_timer #(
      .NUM_CH(NUM_CH),
      .CNT_W(32),
      .RESET_PERIOD(32'h22E97)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus),
      .irq_vec(irq_vec),
      .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.address    = a;
      bus.writedata  = d;
      @(posedge clk);
      #1;
      last_edge      = cyc;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] e, input string nm);
      sb_t s;
      @(negedge clk);
      bus.chipselect = 1'b1;
      bus.read_n     = 1'b0;
      bus.address    = a;
      s.exp  = e;
      s.name = nm;
      sb_q.push_back(s);
      @(posedge clk);
      #1;
      s = sb_q.pop_front();
      chk(s.name, bus.readdata, s.exp);
      bus.chipselect = 1'b0;
      bus.read_n     = 1'b1;
   endtask

   task automatic wait_rise(input int idx, input int max_cyc, input string nm);
      bit found;
      found     = 1'b0;
      last_rise = -1;
      for (int k = 0; k < max_cyc && !found; k++) begin
         @(posedge clk);
         #1;
         if (irq_vec[idx]) begin
            found     = 1'b1;
            last_rise = cyc;
         end
      end
      if (!found) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: irq_vec[%0d] not seen within %0d cycles", nm, idx, max_cyc);
      end
   endtask

   function automatic void add(input bit w, input logic [4:0] a, input logic [31:0] d, input string n);
      vec_t v;
      v.wr   = w;
      v.addr = a;
      v.data = d;
      v.name = n;
      vecs.push_back(v);
   endfunction

   initial begin
      int t0;
      int t1;
      int s1;
      int s2;
      int r;

      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.read_n     = 1'b1;
      bus.address    = '0;
      bus.writedata  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_irq_vec", 32'(irq_vec), 32'h0);
      chk("rst_readdata", bus.readdata, 32'h0);

      // Readdata latency: the new address shows up only after the next edge.
      @(negedge clk);
      bus.address = 5'h00;
      @(posedge clk);
      #1;
      chk("lat_status", bus.readdata, 32'h0);
      @(negedge clk);
      bus.address = 5'h02;
      #1;
      chk("lat_hold", bus.readdata, 32'h0);
      @(posedge clk);
      #1;
      chk("lat_1cyc", bus.readdata, 32'h0002_2E97);

      // Register vectors: wr=1 writes data; wr=0 reads and expects data.
      add(0, 5'h02, 32'h0002_2E97, "rst_period0");
      add(0, 5'h00, 32'h0,         "rst_status0");
      add(0, 5'h01, 32'h0,         "rst_ctrl0");
      add(0, 5'h03, 32'h0,         "rst_snap0");
      add(0, 5'h1A, 32'h0002_2E97, "rst_period3");
      add(0, 5'h05, 32'h0,         "rst_irqvec");
      add(1, 5'h01, 32'h3,         "");
      add(0, 5'h01, 32'h3,         "ctrl_rw");
      add(0, 5'h00, 32'h0,         "status_norun");
      add(1, 5'h01, 32'hC,         "");
      add(0, 5'h01, 32'h0,         "ctrl_strobes_rd0");
      add(0, 5'h00, 32'h2,         "start_wins");
      add(1, 5'h01, 32'h8,         "");
      add(0, 5'h00, 32'h0,         "stop");
      add(1, 5'h0A, 32'hDEAD_BEEF, "");
      add(0, 5'h0A, 32'hDEAD_BEEF, "period_rw");
      add(1, 5'h0E, 32'hFFFF_FFFF, "");
      add(0, 5'h0E, 32'h0,         "reg6_rd0");
      add(0, 5'h0F, 32'h0,         "reg7_rd0");
      add(1, 5'h04, 32'h0001_2345, "");
      add(0, 5'h04, EXP_PS,        "prescale_rw");
      add(1, 5'h04, 32'h0,         "");
      add(0, 5'h04, 32'h0,         "prescale_zero");
      add(1, 5'h08, 32'hFFFF_FFFF, "");
      add(0, 5'h08, 32'h0,         "status_ro");
      add(0, 5'h0D, 32'h0,         "irqvec_ch1");
      add(1, 5'h1B, 32'h0,         "");
      add(0, 5'h1B, 32'h0002_2E97, "snap_idle");
      foreach (vecs[i]) begin
         if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
         else            rd(vecs[i].addr, vecs[i].data, vecs[i].name);
      end

      // ch1 continuous, PERIOD=9: a timeout every 10 clocks.
      wr(5'h0A, 32'd9);
      wr(5'h09, 32'h7);
      t0 = last_edge;
      wait_rise(1, 40, "t2_first");
      chk("t2_first_lat", 32'(last_rise - t0), 32'd10);
      chk("t2_irq_or", 32'(irq), 32'h1);
      t1 = last_rise;
      rd(5'h05, 32'h2, "t2_irqvec_ch0");
      rd(5'h1D, 32'h2, "t2_irqvec_ch3");
      wr(5'h08, 32'h0);
      chk("t2_irq_drop", 32'(irq), 32'h0);
      wait_rise(1, 40, "t2_second");
      chk("t2_interval1", 32'(last_rise - t1), 32'd10);
      t1 = last_rise;
      wr(5'h08, 32'h0);
      wait_rise(1, 40, "t2_third");
      chk("t2_interval2", 32'(last_rise - t1), 32'd10);
      wr(5'h09, 32'h8);
      wr(5'h08, 32'h0);
      chk("t2_stopped", 32'(irq_vec), 32'h0);

      // ch2 one-shot, PERIOD=5: a single timeout, then the counter holds at 0.
      wr(5'h12, 32'd5);
      wr(5'h11, 32'h5);
      t0 = last_edge;
      wait_rise(2, 30, "t3_event");
      chk("t3_lat", 32'(last_rise - t0), 32'd6);
      rd(5'h10, 32'h1, "t3_status");
      wr(5'h13, 32'h0);
      rd(5'h13, 32'h0, "t3_cnt_held");
      repeat (20) @(posedge clk);
      #1;
      wr(5'h13, 32'h0);
      rd(5'h13, 32'h0, "t3_cnt_held_late");
      wr(5'h10, 32'h0);
      rd(5'h10, 32'h0, "t3_status_clr");
      repeat (20) @(posedge clk);
      #1;
      chk("t3_no_repeat", 32'(irq_vec[2]), 32'h0);
      wr(5'h11, 32'h0);

      // ch0 running. START+STOP keeps it running; two SNAPs 3 clocks apart.
      wr(5'h02, 32'd1000);
      wr(5'h01, 32'h6);
      t0 = last_edge;
      wr(5'h01, 32'hC);
      rd(5'h00, 32'h2, "t4_still_run");
      wr(5'h03, 32'h0);
      s1 = last_edge;
      rd(5'h03, 32'(1000 - (s1 - 1 - t0)), "t4_snap1");
      @(posedge clk);
      wr(5'h03, 32'h0);
      s2 = last_edge;
      rd(5'h03, 32'(1000 - (s2 - 1 - t0)), "t4_snap2");
      wr(5'h01, 32'h8);

      // ch3 PERIOD=20 continuous.
      // A clear that lands on the event cycle wins; a PERIOD write stops and reloads.
      wr(5'h1A, 32'd20);
      wr(5'h19, 32'h7);
      wait_rise(3, 60, "t5_event");
      r = last_rise;
      wr(5'h18, 32'h0);
      chk("t5_clr", 32'(irq_vec[3]), 32'h0);
      while (cyc < r + 20) begin
         @(posedge clk);
         #1;
      end
      wr(5'h18, 32'h0);
      chk("t5_clear_wins", 32'(irq_vec[3]), 32'h0);
      wait_rise(3, 40, "t5_next_event");
      chk("t5_next_at", 32'(last_rise - r), 32'd42);
      wr(5'h18, 32'h0);
      wr(5'h1A, 32'd100);
      rd(5'h18, 32'h0, "t5_run_cleared");
      wr(5'h1B, 32'h0);
      rd(5'h1B, 32'd100, "t5_reload");
      repeat (5) @(posedge clk);
      #1;
      wr(5'h1B, 32'h0);
      rd(5'h1B, 32'd100, "t5_held");
      wr(5'h19, 32'h0);

`ifdef TIMER_PRESCALER_EN
      // ch2 PRESCALE=3, PERIOD=4: a timeout every 20 clocks.
      wr(5'h14, 32'd3);
      wr(5'h12, 32'd4);
      wr(5'h11, 32'h7);
      t0 = last_edge;
      wait_rise(2, 60, "t6_first");
      chk("t6_first_lat", 32'(last_rise - t0), 32'd17);
      t1 = last_rise;
      wr(5'h10, 32'h0);
      wait_rise(2, 60, "t6_second");
      chk("t6_interval", 32'(last_rise - t1), 32'd20);
      wr(5'h11, 32'h8);
      wr(5'h10, 32'h0);
`endif

      // Asynchronous reset in the middle of a count.
      wr(5'h09, 32'h7);
      wait_rise(1, 40, "t7_running");
      @(negedge clk);
      bus.address = 5'h0A;
      repeat (2) @(posedge clk);
      #1;
      chk("t7_pre_rd", bus.readdata, 32'd9);
      chk("t7_pre_irq", 32'(irq), 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t7_rst_irq", 32'(irq), 32'h0);
      chk("t7_rst_irq_vec", 32'(irq_vec), 32'h0);
      chk("t7_rst_rd", bus.readdata, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      rd(5'h0A, 32'h0002_2E97, "t7_period");
      rd(5'h08, 32'h0, "t7_status");
      rd(5'h09, 32'h0, "t7_ctrl");
      repeat (30) @(posedge clk);
      #1;
      chk("t7_quiet", 32'(irq), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
